// File: rtl/approx_mult_pipe.sv
// Three-stage pipelined W x W unsigned multiplier, per-beat exact or approximate mode.
// Define APPROX_ERR_MON_EN to add the err_abs / err_max error-monitor outputs.
module approx_mult_pipe #(
   parameter int unsigned  W         = 8,
   parameter logic [W-1:0] LSB_CONST = W'(6),
   parameter int unsigned  TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic             in_exact,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_p,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_exact
`ifdef APPROX_ERR_MON_EN
   ,
   output logic [2*W-1:0]   err_abs,
   output logic [2*W-1:0]   err_max
`endif
);

   localparam int unsigned PW = 2 * W;
   localparam int unsigned NR = W + 1;

   logic adv;

   // Stage 1: AND array, diagonal compensation, registered partial-product rows
   logic [PW-1:0]    keep;
   logic             e1, e2;
   logic [PW-1:0]    pp_d [NR];
   logic [PW-1:0]    pp_q [NR];
   logic             v1_q, ex1_q;
   logic [TAG_W-1:0] tag1_q;

   // Stage 2: carry-save rows
   logic [PW-1:0]    sum_d, car_d;
   logic [PW-1:0]    sum_q, car_q;
   logic             v2_q, ex2_q;
   logic [TAG_W-1:0] tag2_q;

   // Stage 3: output registers
   logic [PW-1:0]    p_full, p_d;
   logic             out_valid_q, out_exact_q;
   logic [PW-1:0]    out_p_q;
   logic [TAG_W-1:0] out_tag_q;

   assign adv      = !out_valid_q | out_ready;
   assign in_ready = adv;

   always_comb begin
      keep = in_exact ? {PW{1'b1}} : {{W{1'b1}}, {W{1'b0}}};
      e1   = 1'b0;
      e2   = 1'b0;
      for (int unsigned i = 0; i < W; i++) begin
         if (i < W / 2) e2 = e2 | (in_a[i] & in_b[W-1-i]);
         else           e1 = e1 | (in_a[i] & in_b[W-1-i]);
      end
      for (int unsigned i = 0; i < W; i++) begin
         pp_d[i] = ((PW'(in_a) & {PW{in_b[i]}}) << i) & keep;
      end
      // e1 + e2 lands in column W as a 2-bit value
      pp_d[W] = in_exact ? '0 : (PW'({e1 & e2, e1 ^ e2}) << W);
   end

   always_ff @(posedge clk) begin
      if (rst)      v1_q <= 1'b0;
      else if (adv) v1_q <= in_valid;
      if (adv) begin
         pp_q   <= pp_d;
         ex1_q  <= in_exact;
         tag1_q <= in_tag;
      end
   end

   // Chain of 3:2 compressors; wrap-around of the top carry is harmless modulo 2^PW
   always_comb begin
      logic [PW-1:0] ps;
      ps    = '0;
      sum_d = pp_q[0];
      car_d = pp_q[1];
      for (int unsigned r = 2; r < NR; r++) begin
         ps    = sum_d ^ car_d ^ pp_q[r];
         car_d = ((sum_d & car_d) | (sum_d & pp_q[r]) | (car_d & pp_q[r])) << 1;
         sum_d = ps;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)      v2_q <= 1'b0;
      else if (adv) v2_q <= v1_q;
      if (adv) begin
         sum_q  <= sum_d;
         car_q  <= car_d;
         ex2_q  <= ex1_q;
         tag2_q <= tag1_q;
      end
   end

   always_comb begin
      p_full = sum_q + car_q;
      p_d    = ex2_q ? p_full : {p_full[PW-1:W], LSB_CONST};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
         out_tag_q   <= '0;
         out_exact_q <= 1'b0;
      end else if (adv) begin
         out_valid_q <= v2_q;
         out_p_q     <= p_d;
         out_tag_q   <= tag2_q;
         out_exact_q <= ex2_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_p     = out_p_q;
   assign out_tag   = out_tag_q;
   assign out_exact = out_exact_q;

`ifdef APPROX_ERR_MON_EN
   logic [PW-1:0] xp1_q, xp2_q, xp3_q, err_max_q;

   always_ff @(posedge clk) begin
      if (adv) begin
         xp1_q <= PW'(in_a) * PW'(in_b);
         xp2_q <= xp1_q;
         xp3_q <= xp2_q;
      end
      if (rst)                          err_max_q <= '0;
      else if (out_valid_q && out_ready && (err_abs > err_max_q)) err_max_q <= err_abs;
   end

   always_comb begin
      if (out_exact_q)             err_abs = '0;
      else if (xp3_q >= out_p_q)   err_abs = xp3_q - out_p_q;
      else                         err_abs = out_p_q - xp3_q;
   end

   assign err_max = err_max_q;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe: W=8 directed/stall/reset scenarios and a W=16 sweep.
module tb_approx_mult_pipe;

   typedef struct {
      logic [15:0] p;
      logic [3:0]  tag;
      logic        ex;
      logic [15:0] err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_exact, out_valid, out_ready, out_exact;
   logic [7:0]  in_a, in_b;
   logic [3:0]  in_tag, out_tag;
   logic [15:0] out_p;

   logic        c_valid, c_ready, c_out_valid, c_out_ready, c_exact, c_out_exact;
   logic [15:0] c_a, c_b;
   logic [3:0]  c_tag, c_out_tag;
   logic [31:0] c_out_p;

`ifdef APPROX_ERR_MON_EN
   logic [15:0] err_abs, err_max;
   logic [31:0] c_err_abs, c_err_max;
`endif

   exp_t        sb[$];
   logic [31:0] sb2[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   approx_mult_pipe #(.W(8), .LSB_CONST(8'd6), .TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_exact  (in_exact),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_tag   (out_tag),
      .out_exact (out_exact)
`ifdef APPROX_ERR_MON_EN
      ,
      .err_abs   (err_abs),
      .err_max   (err_max)
`endif
   );

   approx_mult_pipe #(.W(16), .LSB_CONST(16'd0), .TAG_W(4)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (c_valid),
      .in_ready  (c_ready),
      .in_a      (c_a),
      .in_b      (c_b),
      .in_exact  (c_exact),
      .in_tag    (c_tag),
      .out_valid (c_out_valid),
      .out_ready (c_out_ready),
      .out_p     (c_out_p),
      .out_tag   (c_out_tag),
      .out_exact (c_out_exact)
`ifdef APPROX_ERR_MON_EN
      ,
      .err_abs   (c_err_abs),
      .err_max   (c_err_max)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Column-by-column reference, independent of any row/mask formulation
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic ex, input int w, input logic [31:0] lc);
      logic [63:0] u;
      logic        e1, e2;
      if (ex) return 64'(a) * 64'(b);
      u  = '0;
      e1 = 1'b0;
      e2 = 1'b0;
      for (int i = 0; i < w; i++)
         for (int j = 0; j < w; j++)
            if (i + j >= w && a[i] && b[j]) u += 64'(1) << (i + j);
      for (int i = 0; i < w; i++)
         if (a[i] && b[w-1-i]) begin
            if (i >= w / 2) e1 = 1'b1;
            else            e2 = 1'b1;
         end
      u += (64'(e1) + 64'(e2)) << w;
      return ((u >> w) << w) | 64'(lc);
   endfunction

   // Offers one beat, waits for acceptance (bounded), records the expected result.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ex,
                       input logic [3:0] tag, input logic [15:0] expp, output int ncyc);
      bit          acc;
      exp_t        e;
      logic [15:0] prod;
      ncyc     = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_exact = ex;
      in_tag   = tag;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         ncyc++;
      end while (!acc && ncyc < 100);
      in_valid = 1'b0;
      if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
      else begin
         prod  = 16'(a) * 16'(b);
         e.p   = expp;
         e.tag = tag;
         e.ex  = ex;
         e.err = ex ? 16'd0 : ((prod >= expp) ? prod - expp : expp - prod);
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
         else begin
            mon_e = sb.pop_front();
            chk("out_p", 64'(out_p), 64'(mon_e.p));
            chk("out_tag", 64'(out_tag), 64'(mon_e.tag));
            chk("out_exact", 64'(out_exact), 64'(mon_e.ex));
`ifdef APPROX_ERR_MON_EN
            chk("err_abs", 64'(err_abs), 64'(mon_e.err));
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && c_out_valid && c_out_ready) begin
         if (sb2.size() == 0) chk("w16_unexpected_output", 64'd1, 64'd0);
         else chk("w16_out_p", 64'(c_out_p), 64'(sb2.pop_front()));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  da [6];
      logic [7:0]  db [6];
      logic        dx [6];
      logic [15:0] dp [6];
      int          nc, total, lat;
      logic [31:0] x;
      logic [7:0]  ra, rb;

      da = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h10, 8'h80};
      db = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h08, 8'h80};
      dx = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      dp = '{16'hF906, 16'hFE01, 16'h0006, 16'h0006, 16'h0106, 16'h4006};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0; in_tag = '0;
      out_ready = 1'b1;
      c_valid = 1'b0; c_a = '0; c_b = '0; c_exact = 1'b0; c_tag = '0; c_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_p", 64'(out_p), 64'd0);
      chk("reset_out_tag", 64'(out_tag), 64'd0);
      chk("reset_out_exact", 64'(out_exact), 64'd0);

      // Directed vectors with hand-computed results
      for (int i = 0; i < 6; i++) send(da[i], db[i], dx[i], 4'(i + 3), dp[i], nc);
      drain();
`ifdef APPROX_ERR_MON_EN
      chk("err_max", 64'(err_max), 64'd1275);
`endif

      // 20 back-to-back beats with alternating mode
      total = 0;
      for (int i = 0; i < 20; i++) begin
         ra = 8'(i * 73 + 29);
         rb = 8'(i * 151 + 5);
         send(ra, rb, i[0], 4'(i), 16'(model(32'(ra), 32'(rb), i[0], 8, 32'd6)), nc);
         total += nc;
      end
      chk("b2b_accept_cycles", 64'(total), 64'd20);
      drain();

      // Stall: fill the pipe with out_ready low, then hold for 5 cycles
      out_ready = 1'b0;
      send(8'h10, 8'h08, 1'b0, 4'hA, 16'h0106, nc);
      send(8'hFF, 8'hFF, 1'b1, 4'hB, 16'hFE01, nc);
      send(8'h80, 8'h80, 1'b0, 4'hC, 16'h4006, nc);
      for (int k = 0; k < 5; k++) begin
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_out_p", 64'(out_p), 64'h0106);
         chk("stall_out_tag", 64'(out_tag), 64'hA);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      drain();

      // Reset with three beats in flight
      out_ready = 1'b0;
      send(8'h21, 8'h43, 1'b1, 4'h1, 16'h08A3, nc);
      send(8'hFF, 8'hFF, 1'b0, 4'h2, 16'hF906, nc);
      send(8'h0F, 8'h0F, 1'b1, 4'h3, 16'h00E1, nc);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_p", 64'(out_p), 64'd0);
      chk("midrst_out_tag", 64'(out_tag), 64'd0);
      chk("midrst_out_exact", 64'(out_exact), 64'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      chk("postrst_in_ready", 64'(in_ready), 64'd1);
      send(8'h0F, 8'h0F, 1'b0, 4'h7, 16'h0006, nc);
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("postrst_latency", 64'(lat), 64'd3);
      drain();

      // W=16, LSB_CONST=0 approximate sweep
      x = 32'h1234_5678;
      for (int i = 0; i < 1000; i++) begin
         x = x * 32'd1103515245 + 32'd12345;
         c_a = x[31:16];
         x = x * 32'd1103515245 + 32'd12345;
         c_b = x[31:16];
         c_valid = 1'b1;
         c_exact = 1'b0;
         c_tag   = 4'(i);
         @(posedge clk);
         #1;
         sb2.push_back(32'(model(32'(c_a), 32'(c_b), 1'b0, 16, 32'd0)));
      end
      c_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("w16_drain_empty", 64'(sb2.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined successor to the team's 8x8 approximate compressor multiplier.
- Unsigned W x W multiplier. Per transaction it runs either in exact mode or in approximate mode: low-half columns dropped, OR-based compensation into column W, low half of the result forced to a constant.
- Three-stage pipeline: partial products and compensation, then reduction, then final carry-propagate add.
- Valid/ready handshake and a tag passthrough; sits in the datapath between the operand FIFO and the accumulator.

Parameters:
- W, 8, operand width; even, 4..32
- LSB_CONST, 6, value driven on o[W-1:0] in approximate mode; width W
- TAG_W, 4, width of the sideband tag carried alongside each operation

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  W  multiplicand (unsigned)
- in_b  in  W  multiplier (unsigned)
- in_exact  in  1  1 = exact product, 0 = approximate
- in_tag  in  TAG_W  sideband, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_p  out  2W  product
- out_tag  out  TAG_W  tag of this result
- out_exact  out  1  mode this result was computed in

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: on rst all stage-valid bits clear, so out_valid=0. out_p, out_tag and out_exact reset to 0. in_ready=1 from the first cycle after reset. A reset mid-operation discards all in-flight beats; nothing is emitted for them.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Pipeline control: global-enable pipeline. adv = !out_valid | out_ready.
  - in_ready = adv.
  - All three stages shift together when adv=1 and hold when adv=0.
  - Bubbles propagate as stage-valid=0.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle while out_ready=1.
- Stall rules: while out_valid=1 and out_ready=0, out_p, out_tag and out_exact are stable. A beat offered with in_ready=0 is not captured and must be held by the source.
- Definitions: p(i,j) = a[i] & b[j]; column k holds p(i,j) with i+j=k.
- Exact mode: out_p = a*b (2W bits, exact).
- Approximate mode:
  - U = sum over columns k>=W of p(i,j)*2^k.
  - e1 = OR of p(i,W-1-i) for i in W/2..W-1.
  - e2 = OR of p(i,W-1-i) for i in 0..W/2-1.
  - out_p[2W-1:W] = (U + (e1+e2)*2^W) >> W.
  - out_p[W-1:0] = LSB_CONST.
  - The upper sum cannot overflow 2W bits for any operands; the implementation must produce this value bit-exactly.
- Stage split:
  - Stage 1: AND array, e1/e2, register partial products plus mode and tag.
  - Stage 2: reduce upper columns to two rows using 4:2/3:2 compressors. In exact mode, low columns are also reduced.
  - Stage 3: final carry-propagate add and LSB_CONST mux.
- Mixing modes: exact and approximate beats may interleave back-to-back. Mode travels with the beat; there are no global mode registers.

Optional Feature:
- Macro: APPROX_ERR_MON_EN.
- When defined:
  - The exact product is also computed for approximate beats.
  - Output err_abs (2W) gives |exact - out_p| for the current result, and 0 for exact beats.
  - Register err_max (2W) holds the running maximum of err_abs over transferred results; it is cleared by rst.
  - Both ports are added to the port list.
- When not defined: neither port exists, and no exact-product logic is built for approximate beats.

Test Plan:
- Reset, then a=255, b=255, approx (W=8) -> 3 cycles later out_p=0xF906, out_tag echoed. With APPROX_ERR_MON_EN: err_abs=1275, err_max=1275.
- a=255, b=255, exact -> out_p=0xFE01. a=0, b=0, approx -> out_p=0x0006. a=1, b=1, approx -> out_p=0x0006.
- 20 back-to-back random beats with alternating in_exact, out_ready=1 -> one result per cycle in order, each matching the reference model, with tags matched.
- out_ready held 0 for 5 cycles after the pipe fills -> in_ready=0, out_p/out_tag stable, no beat lost or duplicated after release.
- Assert rst with 3 beats in flight -> out_valid=0 next cycle and the outputs are 0; a new beat after reset emerges after exactly 3 cycles.
- W=16, LSB_CONST=0: 1000 random approx beats -> out_p[15:0]=0 and the upper half matches the U+e1+e2 model.
